// File: rtl/crc_unfold3_arb.sv
// Two-requester round-robin front end for a 3-bit-unfolded CRC-5 (G = x^5+x^2+1).
// Messages are consumed MSB first, 3 bits per clock; the result is held until taken.
module crc_unfold3_arb #(
    parameter int MSG_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    input  logic [MSG_W-1:0] data_in0,
    input  logic [MSG_W-1:0] data_in1,
    output logic [1:0]       req_ready,
    output logic             busy,
    output logic             res_valid,
    output logic             res_id,
    output logic [4:0]       data_out,
    input  logic             res_ready
);
    localparam int BEATS = MSG_W / 3;
    localparam int CW    = $clog2(BEATS) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [MSG_W-1:0] sr;
    logic [4:0]       r;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             gnt;

    // Three chained serial LFSR steps; bits[2] is the earliest bit on the wire.
    function automatic logic [4:0] crc_step3(input logic [4:0] r_in, input logic [2:0] bits);
        logic [4:0] rr;
        logic       fb;
        rr = r_in;
        for (int i = 2; i >= 0; i--) begin
            fb = rr[4] ^ bits[i];
            rr = {rr[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        return rr;
    endfunction

    // On a tie the requester not served last wins; otherwise whoever is asking.
    always_comb begin
        gnt = (&req_valid) ? ~last : req_valid[1];
    end

    assign req_ready = (state == IDLE && reset && (|req_valid)) ?
                       (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign data_out  = r;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            sr        <= '0;
            r         <= '0;
            cnt       <= '0;
            last      <= 1'b1;
            res_id    <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        sr     <= gnt ? data_in1 : data_in0;
                        r      <= '0;
                        cnt    <= '0;
                        last   <= gnt;
                        res_id <= gnt;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    r   <= crc_step3(r, sr[MSG_W-1 -: 3]);
                    sr  <= sr << 3;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_BEAT) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crc_unfold3_arb.sv
// Bench for crc_unfold3_arb: table vectors, directed corner sequences and a
// randomized run, all checked every cycle against a job-level reference model.
module tb_crc_unfold3_arb;
    localparam int MSG_W = 6;
    localparam int BEATS = MSG_W / 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid;
    logic [MSG_W-1:0] data_in0, data_in1;
    logic [1:0]       req_ready;
    logic             busy, res_valid, res_id;
    logic [4:0]       data_out;
    logic             res_ready;

    crc_unfold3_arb #(.MSG_W(MSG_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .data_in0(data_in0), .data_in1(data_in1), .req_ready(req_ready),
        .busy(busy), .res_valid(res_valid), .res_id(res_id),
        .data_out(data_out), .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: job phase 0=idle 1=computing 2=result held.
    int         m_phase = 0;
    int         m_left  = 0;
    logic       m_last  = 1'b1;
    logic       m_id    = 1'b0;
    logic [4:0] m_crc   = '0;
    logic [4:0] m_dout  = '0;
    logic [1:0] last_rr;
    logic       seen_rv, seen_id;
    logic [4:0] seen_do;

    // M(x)*x^5 mod G(x) by polynomial long division.
    function automatic logic [4:0] ref_crc(input logic [MSG_W-1:0] m);
        logic [63:0] v;
        v = 64'(m) << 5;
        for (int b = MSG_W + 4; b >= 5; b--)
            if (v[b]) v = v ^ (64'd37 << (b - 5));
        return v[4:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        logic       g;
        logic [1:0] exp_rr;
        @(negedge clk);
        #1;
        g = (&req_valid) ? ~m_last : req_valid[1];
        exp_rr = (m_phase == 0 && reset && (|req_valid)) ? (g ? 2'b10 : 2'b01) : 2'b00;
        chk("req_ready", 32'(req_ready), 32'(exp_rr));
        chk("res_valid", 32'(res_valid), 32'(m_phase == 2));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        if (m_phase == 2) chk("res_id", 32'(res_id), 32'(m_id));
        if (m_phase != 1) chk("data_out", 32'(data_out), 32'(m_dout));
        last_rr = exp_rr;
        seen_rv = res_valid;
        seen_id = res_id;
        seen_do = data_out;
        if (!reset) begin
            m_phase = 0; m_last = 1'b1; m_id = 1'b0; m_dout = '0;
        end else begin
            case (m_phase)
                0: if (|req_valid) begin
                    m_id = g; m_last = g;
                    m_crc = ref_crc(g ? data_in1 : data_in0);
                    m_left = BEATS; m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = 2; m_dout = m_crc; end
                end
                default: if (res_ready) m_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic             id;
        logic [MSG_W-1:0] msg;
        logic [4:0]       crc;
    } vec_t;

    vec_t tbl[4];
    int   res_cyc[$];
    int   cyc;
    bit   got;

    initial begin
        tbl[0] = '{1'b0, 6'b101011, 5'b10011};
        tbl[1] = '{1'b1, 6'b111111, 5'b11101};
        tbl[2] = '{1'b0, 6'b000000, 5'b00000};
        tbl[3] = '{1'b1, 6'b000001, 5'b00101};

        reset = 1'b0; req_valid = 2'b00; data_in0 = '0; data_in1 = '0; res_ready = 1'b0;
        cycle(); cycle();
        reset = 1'b1;
        cycle();

        // Table jobs with the expected remainder written out by hand.
        foreach (tbl[t]) begin
            req_valid = tbl[t].id ? 2'b10 : 2'b01;
            if (tbl[t].id) data_in1 = tbl[t].msg; else data_in0 = tbl[t].msg;
            res_ready = 1'b1;
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                cycle();
                if (last_rr != 2'b00) req_valid = 2'b00;
                if (seen_rv) begin
                    got = 1'b1;
                    chk("tbl_crc", 32'(seen_do), 32'(tbl[t].crc));
                    chk("tbl_id", 32'(seen_id), 32'(tbl[t].id));
                end
            end
            if (!got) chk("tbl_timeout", 0, 1);
            cycle();
        end

        // Both requesting continuously: strict alternation, one result per 4 cycles.
        reset = 1'b0; req_valid = 2'b00; cycle(); reset = 1'b1;
        data_in0 = 6'b101011; data_in1 = 6'b111111; req_valid = 2'b11; res_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            cycle();
            if (seen_rv) res_cyc.push_back(k);
        end
        chk("alt_count", 32'(res_cyc.size()), 32'd4);
        for (int i = 1; i < res_cyc.size(); i++)
            chk("alt_period", 32'(res_cyc[i] - res_cyc[i-1]), 32'd4);

        // Backpressure in DONE with both requesters waiting.
        res_ready = 1'b0;
        for (int k = 0; k < 9; k++) cycle();
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) cycle();

        // Reset in the middle of a computation, then a fresh job.
        req_valid = 2'b01; data_in0 = 6'b110101;
        cycle();
        req_valid = 2'b00;
        cycle();
        reset = 1'b0; cycle(); reset = 1'b1;
        chk("rst_dout", 32'(data_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req_valid = 2'b10; data_in1 = 6'b000001;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (last_rr != 2'b00) req_valid = 2'b00;
        end

        // Randomized traffic; requesters hold valid and data until accepted.
        for (cyc = 0; cyc < 400; cyc++) begin
            if (!req_valid[0] && $urandom_range(0, 2) == 0) begin
                req_valid[0] = 1'b1; data_in0 = MSG_W'($urandom);
            end
            if (!req_valid[1] && $urandom_range(0, 2) == 0) begin
                req_valid[1] = 1'b1; data_in1 = MSG_W'($urandom);
            end
            res_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 49) != 0);
            cycle();
            if (last_rr[0]) req_valid[0] = 1'b0;
            if (last_rr[1]) req_valid[1] = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/crc_unfold3_arb.md
# crc_unfold3_arb

Two-requester round-robin arbiter and sequencer for the 3-bit-unfolded CRC-5 engine. Each requester hands over a MSG_W-bit message through a valid/ready handshake. The block feeds the message into its internal unfolded LFSR 3 bits per clock, MSB first. It then presents the 5-bit remainder, tagged with the requester id, on a held result port. It sits between the packet-framing front ends and the single CRC datapath they share.

## Interface
- MSG_W, 6: message width in bits; must be a non-zero multiple of 3.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- req_valid  input  2  bit i: requester i presents a message.
- data_in0  input  MSG_W  requester 0 message, MSB transmitted first.
- data_in1  input  MSG_W  requester 1 message.
- req_ready  output  2  bit i: requester i's message is taken this cycle (combinational).
- busy  output  1  high in RUN and DONE.
- res_valid  output  1  result available.
- res_id  output  1  requester that owns the current result.
- data_out  output  5  CRC-5 remainder.
- res_ready  input  1  consumer accepts the result.

## Operation
- CRC: G(x)=x^5+x^2+1 (feedback mask 5'b00101). Init 0, non-reflected, no final XOR. Output is M(x)·x^5 mod G(x).
- Serial step per bit b: fb=r[4]^b; r={r[3:0],1'b0}^(fb?5'b00101:0).
- Unfolded update: three serial steps chained combinationally per clock, using bits [MSG_W-1:MSG_W-3] of the shift register in that order.
- States: IDLE, RUN, DONE.
- IDLE:
  - Grant g is chosen when any req_valid bit is set.
  - If both are set, g is the requester not served last.
  - If only one is set, g is that requester.
  - req_ready[g]=1 combinationally; the other bit is 0.
  - On the edge: load shift register with data_in_g, clear r to 0, clear beat counter, record last=g and res_id=g, go to RUN.
  - With no valid, req_ready=0 and the block stays in IDLE.
- RUN:
  - Each cycle: apply the unfolded update, shift the register left 3, increment the counter.
  - After the MSG_W/3-th update, go to DONE.
  - req_ready=0.
- DONE:
  - res_valid=1; data_out=r and res_id are held stable.
  - When res_ready=1, go to IDLE with res_valid=0 on the next cycle.
  - No new request is accepted in the same cycle.
- Requester i must hold req_valid[i] and data_in_i until req_ready[i]. Changes before the handshake are ignored; the message is captured only at the accepting edge.
- req_ready is 0 outside IDLE, so valid during RUN/DONE just waits.
- Beat counter width: clog2(MSG_W/3)+1. Wrap-around cannot occur because it is cleared on every accept.

## Timing
- Reset (reset=0 at an edge):
  - state=IDLE, r=0, data_out=0, res_valid=0, res_id=0, busy=0, last=1 (requester 0 wins the first tie).
  - req_ready=0 while reset is low.
- Reset mid-RUN or mid-DONE abandons the job. No result is produced, and the requester is not re-served unless it re-requests.
- Accept at edge k (IDLE, valid&ready). RUN occupies cycles k+1…k+MSG_W/3. res_valid is high from cycle k+MSG_W/3+1.
  - For MSG_W=6: res_valid in cycle k+3.
- With res_ready tied high, the minimum initiation interval is MSG_W/3+2 cycles (4 for MSG_W=6).
- busy rises the cycle after accept and falls the cycle after the res_ready handshake.
- Simultaneous requests: the arbiter alternates strictly. A requester holding valid continuously waits at most one other job.
- res_ready asserted while res_valid=0 has no effect.

## Test plan
- Reset then single job, MSG_W=6: req_valid=2'b01, data_in0=6'b101011, res_ready=1 → req_ready=2'b01 on the accept cycle; res_valid in cycle k+3 with data_out=5'b10011, res_id=0.
- Requester 1 alone: data_in1=6'b111111 → data_out=5'b11101, res_id=1.
- Both valid continuously after reset, data_in0=101011, data_in1=111111, res_ready=1:
  - Results alternate res_id 0,1,0,1 with data_out 10011,11101,…
  - res_valid pulses every 4 cycles.
- Backpressure: res_ready=0 for 5 cycles during DONE → data_out/res_id/res_valid stay stable; req_ready stays 0 although req_valid=2'b11; resume on res_ready=1.
- Reset pulled low during RUN → next cycle: res_valid=0, busy=0, data_out=0; a fresh job afterward gives the correct CRC.
- All-zero message 6'b000000 → data_out=5'b00000. Single-bit message 6'b000001 → data_out=5'b00101 (x^5 mod G).
